pc_sequencer: RTL

Registered, parametrised program-counter sequencer for the MIPS-style core; it replaces the purely combinational next-PC selector. It holds the PC in a register and computes the next value from the decoded opcode: hold/halt, absolute jump, ALU-conditional relative branch, call/return through a return-address stack (RAS), or sequential increment. It sits between the decoder/ALU and the instruction memory address port, and adds stall, halt/resume and stack-fault reporting.

---
 rtl/pc_sequencer.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program-counter sequencer for the MIPS-style core.
//
// The PC is held in a register. Its next value is chosen from the decoded opcode:
//   - halt (0000)
//   - absolute jump (0101)
//   - ALU-conditional relative branch (0110)
//   - call (0111) / return (1000) through a return-address stack
//   - otherwise, sequential increment.
// All PC arithmetic wraps modulo 2^PC_W.
//
// Build option:
//   PC_RAS_EN - when defined, the return-address stack, the call/return opcodes
//               and the overflow/underflow flags are built. When undefined,
//               call/return act as plain increments and both flags are tied to 0.
//
// Parameters:
//   PC_W      PC, jump-target and branch-offset width
//   OP_W      opcode width (encodings occupy the low 4 bits, upper bits must be 0)
//   RAS_DEPTH return-address stack entries (>= 1)
//   RESET_PC  PC value loaded at reset
//
// Ports:
//   clk           rising-edge clock
//   reset_n       asynchronous active-low reset
//   stall         freezes all state for the cycle (beats every opcode and resume)
//   resume        leaves the HALT state
//   op_code       opcode of the instruction at the current pc
//   inst_addr     absolute jump / call target
//   next_addr     unsigned branch offset
//   ALU           ALU result; the branch is taken when it equals 1
//   pc            current PC (registered)
//   halted        high while in HALT
//   ras_overflow  sticky: call made with the stack full
//   ras_underflow sticky: return made with the stack empty
module pc_sequencer #(
    parameter int unsigned     PC_W      = 8,
    parameter int unsigned     OP_W      = 4,
    parameter int unsigned     RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall,
    input  logic            resume,
    input  logic [OP_W-1:0] op_code,
    input  logic [PC_W-1:0] inst_addr,
    input  logic [PC_W-1:0] next_addr,
    input  logic [3:0]      ALU,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            ras_overflow,
    output logic            ras_underflow
);

    localparam logic [OP_W-1:0] OP_HALT   = OP_W'(4'h0);
    localparam logic [OP_W-1:0] OP_JUMP   = OP_W'(4'h5);
    localparam logic [OP_W-1:0] OP_BRANCH = OP_W'(4'h6);

    typedef enum logic {
        S_RUN,
        S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;

`ifdef PC_RAS_EN
    localparam logic [OP_W-1:0] OP_CALL = OP_W'(4'h7);
    localparam logic [OP_W-1:0] OP_RET  = OP_W'(4'h8);
    localparam int unsigned     CNT_W   = $clog2(RAS_DEPTH + 1);
    localparam int unsigned     IDX_W   = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;

    logic [PC_W-1:0]  ras_mem [RAS_DEPTH];
    logic [CNT_W-1:0] ras_cnt;
    logic [IDX_W-1:0] push_idx, pop_idx;
    logic [PC_W-1:0]  ras_top;
    logic             ras_full, ras_empty;
    logic             push, pop;
    logic             ovf_q, unf_q, ovf_set, unf_set;

    assign ras_full  = (ras_cnt == CNT_W'(RAS_DEPTH));
    assign ras_empty = (ras_cnt == '0);
    assign push_idx  = IDX_W'(ras_cnt);
    assign pop_idx   = IDX_W'(ras_cnt - CNT_W'(1));
    assign ras_top   = ras_mem[pop_idx];
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
`ifdef PC_RAS_EN
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
`endif
        if (!stall) begin
            case (state_q)
                S_RUN: begin
                    if (op_code == OP_HALT) begin
                        state_d = S_HALT;
                    end else if (op_code == OP_JUMP) begin
                        pc_d = inst_addr;
                    end else if (op_code == OP_BRANCH) begin
                        pc_d = (ALU == 4'd1) ? pc_q + next_addr + PC_W'(2)
                                             : pc_q + PC_W'(2);
`ifdef PC_RAS_EN
                    end else if (op_code == OP_CALL) begin
                        // The jump happens even when the push is dropped.
                        pc_d = inst_addr;
                        if (ras_full) ovf_set = 1'b1;
                        else          push    = 1'b1;
                    end else if (op_code == OP_RET) begin
                        if (ras_empty) begin
                            pc_d    = pc_q + PC_W'(1);
                            unf_set = 1'b1;
                        end else begin
                            pc_d = ras_top;
                            pop  = 1'b1;
                        end
`endif
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
                S_HALT: begin
                    if (resume) begin
                        pc_d    = pc_q + PC_W'(1);
                        state_d = S_RUN;
                    end
                end
                default: state_d = S_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RUN;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

`ifdef PC_RAS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ras_cnt <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int unsigned i = 0; i < RAS_DEPTH; i++) ras_mem[i] <= '0;
        end else begin
            if (push) begin
                ras_mem[push_idx] <= pc_q + PC_W'(1);
                ras_cnt           <= ras_cnt + CNT_W'(1);
            end else if (pop) begin
                ras_cnt <= ras_cnt - CNT_W'(1);
            end
            if (ovf_set) ovf_q <= 1'b1;
            if (unf_set) unf_q <= 1'b1;
        end
    end

    assign ras_overflow  = ovf_q;
    assign ras_underflow = unf_q;
`else
    assign ras_overflow  = 1'b0;
    assign ras_underflow = 1'b0;
`endif

    assign pc     = pc_q;
    assign halted = (state_q == S_HALT);

endmodule
